vregfile_lanes: RTL and testbench
=================================

Name: vregfile_lanes

Overview:
Parametrised vector register file for the vector datapath.
- NREGS registers, each LANES elements of DATA_W bits.
- Two combinational full-vector read ports.
- One lane-masked write port with write-through bypass.
- A streaming element-load sequencer that fills one register one element per cycle (valid/ready), then commits it atomically.
- Sits between the vector decode/ALU stage and the memory load path.

Parameters:
- DATA_W, 32, element width in bits
- LANES, 5, elements per vector register
- NREGS, 15, number of vector registers
- ADDR_W, 4, register address width; must satisfy 2^ADDR_W >= NREGS
- LIDX_W, 3, lane index width; must satisfy 2^LIDX_W >= LANES

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  synchronous, active-high reset
- vector_op  in  1  read-port qualifier; read data forced to 0 when low
- ra1  in  ADDR_W  read address A
- ra2  in  ADDR_W  read address B
- rd1  out  LANES*DATA_W  vector A; lane i occupies bits [i*DATA_W +: DATA_W]
- rd2  out  LANES*DATA_W  vector B, same packing as rd1
- we3  in  1  write enable
- wa3  in  ADDR_W  write address
- wd3  in  LANES*DATA_W  write data, same packing as rd1
- wmask  in  LANES  per-lane write enable; bit i gates lane i
- ld_start  in  1  start element load
- ld_wa  in  ADDR_W  load target register
- ld_valid  in  1  element valid
- ld_data  in  DATA_W  element data
- ld_ready  out  1  sequencer accepts an element this cycle
- ld_busy  out  1  sequencer not IDLE
- ld_done  out  1  one-cycle pulse in the commit cycle

Behaviour:
Clock and reset:
- Single clock clk; reset is synchronous and active-high.
- On reset, all registers clear to 0, FSM goes to IDLE, the lane counter clears, and the staging buffer clears.
- Outputs during and after reset: ld_ready=0, ld_busy=0, ld_done=0.
- rd1 and rd2 read 0 after reset.

Reads:
- rd1 and rd2 are combinational, with zero latency.
- When vector_op=0, the output is 0 (never X).
- An address >= NREGS reads 0.

Port write:
- On a clk edge with we3=1 and wa3<NREGS, lane i of rf[wa3] is written only where wmask[i]=1.
- wa3 >= NREGS: write ignored.
- wmask=0: no change.

Bypass:
- If we3=1 and wa3==ra1 (or ra2) in the same cycle, the corresponding read port shows wd3 on masked lanes and the stored value on unmasked lanes.
- The sequencer commit is not bypassed.

FSM (IDLE, FILL, COMMIT):
- IDLE: ld_ready=0, ld_busy=0.
  - ld_start=1 with ld_wa<NREGS: capture ld_wa, clear the lane counter, go to FILL.
  - ld_wa >= NREGS: ld_start ignored.
- FILL: ld_ready=1, ld_busy=1.
  - Each cycle with ld_valid=1 stores ld_data into staging[counter] and increments the counter.
  - Acceptance of lane LANES-1 goes to COMMIT.
  - ld_valid=0 stalls indefinitely with no timeout.
- COMMIT: ld_ready=0, ld_busy=1, ld_done=1.
  - All LANES of staging are written to rf[captured addr].
  - Next state is IDLE; a new ld_start is accepted the following cycle.

Conflict and boundary rules:
- ld_start while not IDLE: ignored; the captured address is unchanged.
- Commit and we3 to different registers in the same cycle: both take effect.
- Commit and we3 to the same register: commit wins on all lanes, and the we3 write is dropped.
- we3 to the load target during FILL: takes effect, then is overwritten at commit.
- Reset mid-FILL or in COMMIT: staging is discarded, no ld_done, the target register is unchanged in a reset-in-COMMIT cycle, and the FSM goes to IDLE.
- The lane counter never exceeds LANES-1; there is no wrap within a load.

Optional Feature:
VREG_HAZARD_EN:
- When defined, adds output port hazard (1 bit, combinational).
- hazard=1 when ld_busy=1 and vector_op=1 and (ra1==captured ld address or ra2==captured ld address).
- Otherwise hazard=0; it reads 0 in reset.
- When not defined, the port does not exist and no comparison logic is built.

Test Plan:
- Reset, then read all addresses with vector_op=1 → rd1=rd2=0; vector_op=0 with nonzero contents → rd1=0.
- we3=1, wa3=3, wd3 lanes = 0x11,0x22,0x33,0x44,0x55, wmask=5'b10101; next cycle ra1=3 → lanes 0x11,0,0x33,0,0x55. In the write cycle with ra2=3 → rd2 shows the same values (bypass).
- ld_start, ld_wa=7; feed 0xA0..0xA4 with ld_valid low for 2 cycles after the second element → ld_done high exactly 1 cycle after the fifth acceptance; rf[7]=0xA0..0xA4; ld_busy low the next cycle.
- Commit cycle to reg 7 with simultaneous we3 wa3=7, wd3 all 0xFF, full mask → rf[7]=0xA0..0xA4.
  - Repeat with wa3=2 → rf[2] all 0xFF and rf[7] loaded.
- Load to reg 4 (preloaded 0x99 all lanes); assert reset after 3 elements → ld_busy=0, no ld_done, rf[4] cleared to 0 by reset; ld_start during FILL to reg 9 ignored → commit goes to reg 4.
- VREG_HAZARD_EN: during FILL to reg 6, ra1=6 → hazard=1; ra1=5, ra2=6 → hazard=1; ra1=ra2=5 → hazard=0; after ld_done → hazard=0.

Source files
------------

// File: rtl/vregfile_lanes.sv
// Vector register file: two combinational read ports, a lane-masked write port with bypass,
// and a valid/ready element-load sequencer. Optional hazard output under VREG_HAZARD_EN.
module vregfile_lanes #(
    parameter int DATA_W = 32,
    parameter int LANES  = 5,
    parameter int NREGS  = 15,
    parameter int ADDR_W = 4,
    parameter int LIDX_W = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     vector_op,
    input  logic [ADDR_W-1:0]        ra1,
    input  logic [ADDR_W-1:0]        ra2,
    output logic [LANES*DATA_W-1:0]  rd1,
    output logic [LANES*DATA_W-1:0]  rd2,
    input  logic                     we3,
    input  logic [ADDR_W-1:0]        wa3,
    input  logic [LANES*DATA_W-1:0]  wd3,
    input  logic [LANES-1:0]         wmask,
    input  logic                     ld_start,
    input  logic [ADDR_W-1:0]        ld_wa,
    input  logic                     ld_valid,
    input  logic [DATA_W-1:0]        ld_data,
    output logic                     ld_ready,
    output logic                     ld_busy,
    output logic                     ld_done
`ifdef VREG_HAZARD_EN
    ,
    output logic                     hazard
`endif
);

    localparam int VW = LANES * DATA_W;

    // Load handshake: an element is accepted on a rising edge where ld_valid && ld_ready.
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_COMMIT} ld_state_t;

    ld_state_t           state_q, state_d;
    logic [LIDX_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [VW-1:0]       stg_q, stg_d;
    logic [VW-1:0]       rf_q [NREGS];

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < NREGS;
    endfunction

    function automatic logic [VW-1:0] read_port(
        input logic              vop,
        input logic [ADDR_W-1:0] ra,
        input logic [VW-1:0]     stored,
        input logic              we,
        input logic [ADDR_W-1:0] wa,
        input logic [VW-1:0]     wd,
        input logic [LANES-1:0]  wm
    );
        logic [VW-1:0] v;
        v = '0;
        if (vop && in_range(ra)) begin
            v = stored;
            if (we && (wa == ra)) begin
                for (int l = 0; l < LANES; l++) begin
                    if (wm[l]) v[l*DATA_W +: DATA_W] = wd[l*DATA_W +: DATA_W];
                end
            end
        end
        return v;
    endfunction

    logic [ADDR_W-1:0] ra1_idx, ra2_idx;

    always_comb begin
        ra1_idx = in_range(ra1) ? ra1 : '0;
        ra2_idx = in_range(ra2) ? ra2 : '0;
        rd1 = read_port(vector_op, ra1, rf_q[ra1_idx], we3, wa3, wd3, wmask);
        rd2 = read_port(vector_op, ra2, rf_q[ra2_idx], we3, wa3, wd3, wmask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        stg_d   = stg_q;
        case (state_q)
            S_IDLE: begin
                if (ld_start && in_range(ld_wa)) begin
                    addr_d  = ld_wa;
                    cnt_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                if (ld_valid) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (cnt_q == LIDX_W'(l)) stg_d[l*DATA_W +: DATA_W] = ld_data;
                    end
                    // Counter holds at the last lane; the commit state ends the load.
                    if (cnt_q == LIDX_W'(LANES-1)) state_d = S_COMMIT;
                    else                           cnt_d   = cnt_q + 1'b1;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign ld_ready = !reset && (state_q == S_FILL);
    assign ld_busy  = !reset && (state_q != S_IDLE);
    assign ld_done  = !reset && (state_q == S_COMMIT);

`ifdef VREG_HAZARD_EN
    assign hazard = ld_busy && vector_op && ((ra1 == addr_q) || (ra2 == addr_q));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            stg_q   <= '0;
            for (int r = 0; r < NREGS; r++) rf_q[r] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            stg_q   <= stg_d;
            // Commit takes every lane of its target; a same-register port write is dropped.
            for (int r = 0; r < NREGS; r++) begin
                if ((state_q == S_COMMIT) && (addr_q == ADDR_W'(r))) begin
                    rf_q[r] <= stg_q;
                end else if (we3 && (wa3 == ADDR_W'(r))) begin
                    for (int l = 0; l < LANES; l++) begin
                        if (wmask[l]) rf_q[r][l*DATA_W +: DATA_W] <= wd3[l*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vregfile_lanes.sv
// Self-checking bench for vregfile_lanes: table-driven port read/write vectors plus
// hand-written load-sequencer sequences, with a queue-based scoreboard for read data.
module tb_vregfile_lanes;

    localparam int DATA_W = 32;
    localparam int LANES  = 5;
    localparam int NREGS  = 15;
    localparam int ADDR_W = 4;
    localparam int LIDX_W = 3;
    localparam int VW     = LANES * DATA_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              vector_op;
    logic [ADDR_W-1:0] ra1, ra2;
    logic [VW-1:0]     rd1, rd2;
    logic              we3;
    logic [ADDR_W-1:0] wa3;
    logic [VW-1:0]     wd3;
    logic [LANES-1:0]  wmask;
    logic              ld_start;
    logic [ADDR_W-1:0] ld_wa;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready, ld_busy, ld_done;
`ifdef VREG_HAZARD_EN
    logic              hazard;
`endif

    vregfile_lanes #(
        .DATA_W(DATA_W), .LANES(LANES), .NREGS(NREGS), .ADDR_W(ADDR_W), .LIDX_W(LIDX_W)
    ) dut (
        .clk(clk), .reset(reset), .vector_op(vector_op),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we3(we3), .wa3(wa3), .wd3(wd3), .wmask(wmask),
        .ld_start(ld_start), .ld_wa(ld_wa), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done)
`ifdef VREG_HAZARD_EN
        , .hazard(hazard)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;
    logic [VW-1:0] exp_q[$];

    function automatic logic [VW-1:0] vec5(input logic [DATA_W-1:0] a, b, c, d, e);
        return {e, d, c, b, a};
    endfunction

    function automatic logic [VW-1:0] splat(input logic [DATA_W-1:0] x);
        return {LANES{x}};
    endfunction

    function automatic logic [VW-1:0] ramp(input logic [DATA_W-1:0] base);
        return vec5(base, base + 1, base + 2, base + 3, base + 4);
    endfunction

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_in();
        vector_op = 1'b0; ra1 = '0; ra2 = '0;
        we3 = 1'b0; wa3 = '0; wd3 = '0; wmask = '0;
        ld_start = 1'b0; ld_wa = '0; ld_valid = 1'b0; ld_data = '0;
    endtask

    // scoreboard
    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [VW-1:0] act);
        logic [VW-1:0] e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %h", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", name, act, e);
            end
        end
    endtask

    task automatic read_chk(input string name, input logic [ADDR_W-1:0] a, input logic [VW-1:0] exp);
        cyc(); idle_in();
        vector_op = 1'b1; ra1 = a; ra2 = a;
        exp_q.push_back(exp);
        exp_q.push_back(exp);
        smp();
        sb_check({name, "_rd1"}, rd1);
        sb_check({name, "_rd2"}, rd2);
    endtask

    task automatic do_load(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] base,
                           input logic cw, input logic [ADDR_W-1:0] cwa, input logic [VW-1:0] cwd);
        cyc(); idle_in();
        ld_start = 1'b1; ld_wa = addr;
        smp();
        check_bit("start_busy", ld_busy, 1'b0);
        check_bit("start_ready", ld_ready, 1'b0);
        for (int e = 0; e < LANES; e++) begin
            if (e == 2) begin
                for (int s = 0; s < 2; s++) begin
                    cyc(); idle_in();
                    smp();
                    check_bit("stall_ready", ld_ready, 1'b1);
                    check_bit("stall_done", ld_done, 1'b0);
                end
            end
            cyc(); idle_in();
            ld_valid = 1'b1; ld_data = base + DATA_W'(e);
            smp();
            check_bit("fill_ready", ld_ready, 1'b1);
            check_bit("fill_busy", ld_busy, 1'b1);
            check_bit("fill_done", ld_done, 1'b0);
        end
        cyc(); idle_in();
        we3 = cw; wa3 = cwa; wd3 = cwd; wmask = '1;
        smp();
        check_bit("commit_done", ld_done, 1'b1);
        check_bit("commit_ready", ld_ready, 1'b0);
        check_bit("commit_busy", ld_busy, 1'b1);
        cyc(); idle_in();
        smp();
        check_bit("after_done", ld_done, 1'b0);
        check_bit("after_busy", ld_busy, 1'b0);
    endtask

    typedef struct {
        logic              vop;
        logic [ADDR_W-1:0] ra1;
        logic [ADDR_W-1:0] ra2;
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [VW-1:0]     wd;
        logic [LANES-1:0]  wm;
        logic [VW-1:0]     e1;
        logic [VW-1:0]     e2;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [VW-1:0] v1, v2, v3, wv;
        v1 = vec5('h11, 'h0, 'h33, 'h0, 'h55);
        v2 = vec5('h11, 'h77, 'h33, 'h0, 'h55);
        v3 = vec5('h1, 'h2, 'h3, 'h4, 'h5);
        wv = vec5('h11, 'h22, 'h33, 'h44, 'h55);
        tbl[0]  = '{1'b1, 4'd0,  4'd1,  1'b0, 4'd0,  '0,          5'b00000, '0, '0};
        tbl[1]  = '{1'b1, 4'd14, 4'd15, 1'b0, 4'd0,  '0,          5'b00000, '0, '0};
        tbl[2]  = '{1'b1, 4'd0,  4'd3,  1'b1, 4'd3,  wv,          5'b10101, '0, v1};
        tbl[3]  = '{1'b1, 4'd3,  4'd0,  1'b0, 4'd0,  '0,          5'b00000, v1, '0};
        tbl[4]  = '{1'b0, 4'd3,  4'd3,  1'b0, 4'd0,  '0,          5'b00000, '0, '0};
        tbl[5]  = '{1'b1, 4'd3,  4'd3,  1'b1, 4'd3,  splat('hFF), 5'b00000, v1, v1};
        tbl[6]  = '{1'b1, 4'd15, 4'd3,  1'b1, 4'd15, splat('hFF), 5'b11111, '0, v1};
        tbl[7]  = '{1'b1, 4'd3,  4'd0,  1'b0, 4'd0,  '0,          5'b00000, v1, '0};
        tbl[8]  = '{1'b1, 4'd3,  4'd14, 1'b1, 4'd3,  splat('h77), 5'b00010, v2, '0};
        tbl[9]  = '{1'b1, 4'd3,  4'd3,  1'b0, 4'd0,  '0,          5'b00000, v2, v2};
        tbl[10] = '{1'b0, 4'd14, 4'd14, 1'b1, 4'd14, v3,          5'b11111, '0, '0};
        tbl[11] = '{1'b1, 4'd14, 4'd3,  1'b0, 4'd0,  '0,          5'b00000, v3, v2};

        // reset
        idle_in();
        reset = 1'b1;
        cyc();
        smp();
        check_bit("rst_ready", ld_ready, 1'b0);
        check_bit("rst_busy", ld_busy, 1'b0);
        check_bit("rst_done", ld_done, 1'b0);
        cyc();
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            cyc(); idle_in();
            vector_op = tbl[i].vop; ra1 = tbl[i].ra1; ra2 = tbl[i].ra2;
            we3 = tbl[i].we; wa3 = tbl[i].wa; wd3 = tbl[i].wd; wmask = tbl[i].wm;
            exp_q.push_back(tbl[i].e1);
            exp_q.push_back(tbl[i].e2);
            smp();
            sb_check($sformatf("tbl%0d_rd1", i), rd1);
            sb_check($sformatf("tbl%0d_rd2", i), rd2);
        end

        // load with stalls; same-register port write in the commit cycle is dropped
        do_load(4'd7, 'hA0, 1'b1, 4'd7, splat('hFF));
        read_chk("ld7_a", 4'd7, ramp('hA0));

        // commit and port write to different registers both land
        do_load(4'd7, 'hB0, 1'b1, 4'd2, splat('hFF));
        read_chk("ld7_b_r2", 4'd2, splat('hFF));
        read_chk("ld7_b_r7", 4'd7, ramp('hB0));

        // out-of-range load target is ignored
        cyc(); idle_in(); ld_start = 1'b1; ld_wa = 4'd15;
        smp();
        cyc(); idle_in();
        smp();
        check_bit("oor_start_busy", ld_busy, 1'b0);

        // reset in the middle of FILL
        cyc(); idle_in(); we3 = 1'b1; wa3 = 4'd4; wd3 = splat('h99); wmask = '1;
        smp();
        read_chk("pre4", 4'd4, splat('h99));
        cyc(); idle_in(); ld_start = 1'b1; ld_wa = 4'd4;
        smp();
        for (int e = 0; e < 3; e++) begin
            cyc(); idle_in(); ld_valid = 1'b1; ld_data = 'hC0 + DATA_W'(e);
            smp();
        end
        cyc(); idle_in(); reset = 1'b1;
        smp();
        check_bit("rstfill_busy", ld_busy, 1'b0);
        check_bit("rstfill_done", ld_done, 1'b0);
        check_bit("rstfill_ready", ld_ready, 1'b0);
        cyc(); idle_in(); reset = 1'b0;
        smp();
        check_bit("postrst_busy", ld_busy, 1'b0);
        check_bit("postrst_done", ld_done, 1'b0);
        read_chk("postrst_r4", 4'd4, '0);
        read_chk("postrst_r7", 4'd7, '0);

        // ld_start during FILL does not retarget the load
        cyc(); idle_in(); ld_start = 1'b1; ld_wa = 4'd4;
        smp();
        for (int e = 0; e < LANES; e++) begin
            cyc(); idle_in(); ld_valid = 1'b1; ld_data = 'hD0 + DATA_W'(e);
            if (e == 0) begin
                ld_start = 1'b1; ld_wa = 4'd9;
            end
            smp();
        end
        cyc(); idle_in();
        smp();
        check_bit("retgt_done", ld_done, 1'b1);
        read_chk("retgt_r4", 4'd4, ramp('hD0));
        read_chk("retgt_r9", 4'd9, '0);

        // reset in the COMMIT cycle
        cyc(); idle_in(); ld_start = 1'b1; ld_wa = 4'd5;
        smp();
        for (int e = 0; e < LANES; e++) begin
            cyc(); idle_in(); ld_valid = 1'b1; ld_data = 'hE0 + DATA_W'(e);
            smp();
        end
        cyc(); idle_in(); reset = 1'b1;
        smp();
        check_bit("rstcmt_done", ld_done, 1'b0);
        check_bit("rstcmt_busy", ld_busy, 1'b0);
        cyc(); idle_in(); reset = 1'b0;
        smp();
        check_bit("rstcmt_after_done", ld_done, 1'b0);
        read_chk("rstcmt_r5", 4'd5, '0);

`ifdef VREG_HAZARD_EN
        cyc(); idle_in(); ld_start = 1'b1; ld_wa = 4'd6; vector_op = 1'b1; ra1 = 4'd6;
        smp();
        check_bit("hz_idle", hazard, 1'b0);
        cyc(); idle_in(); vector_op = 1'b1; ra1 = 4'd6; ra2 = 4'd0;
        smp();
        check_bit("hz_ra1", hazard, 1'b1);
        cyc(); idle_in(); vector_op = 1'b1; ra1 = 4'd5; ra2 = 4'd6;
        smp();
        check_bit("hz_ra2", hazard, 1'b1);
        cyc(); idle_in(); vector_op = 1'b1; ra1 = 4'd5; ra2 = 4'd5;
        smp();
        check_bit("hz_none", hazard, 1'b0);
        cyc(); idle_in(); vector_op = 1'b0; ra1 = 4'd6; ra2 = 4'd6;
        smp();
        check_bit("hz_novop", hazard, 1'b0);
        for (int e = 0; e < LANES; e++) begin
            cyc(); idle_in(); ld_valid = 1'b1; ld_data = 'hF0 + DATA_W'(e);
            smp();
        end
        cyc(); idle_in(); vector_op = 1'b1; ra1 = 4'd6;
        smp();
        check_bit("hz_commit", hazard, 1'b1);
        check_bit("hz_commit_done", ld_done, 1'b1);
        cyc(); idle_in(); vector_op = 1'b1; ra1 = 4'd6;
        smp();
        check_bit("hz_after", hazard, 1'b0);
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
